life_gen_sequencer: RTL and testbench

//   Sequences the Game-of-Life grid datapath from the mode controls (rst/strt/rnd) of the top-level mode FSM.

---
 rtl/life_gen_sequencer.sv | 137 +++++++++++++
 tb/tb_life_gen_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/life_gen_sequencer.sv
// Purpose : sequences the Game-of-Life grid register (clear / LFSR seed / timed or single-step commit).
// Latency : one commit per (BASE_DIV<<div_sel)+1 cycles in free-run; tick one cycle after the commit.
// Backpressure: none; step_req edges outside HOLD are dropped, not queued.
//
// Ports:
//   clk, reset           system clock, synchronous active-low reset
//   rst_mode/rnd_mode/play_mode  mode controls, priority rst > rnd > play
//   step_req             single-step request level (rising edge used, HOLD only)
//   div_sel              rate select, period = BASE_DIV<<div_sel
//   lfsr_q / lfsr_en     LFSR state in / advance strobe out (SEED only, combinational)
//   next_grid / grid_q   life-rule result in / registered grid out
//   gen_count, tick, stable, extinct   registered status
module life_gen_sequencer #(
    parameter int GRID_BITS      = 64,
    parameter int BASE_DIV       = 4,
    parameter int DIV_W          = 24,
    parameter int GEN_W          = 16,
    parameter bit STOP_ON_STABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rst_mode,
    input  logic                 play_mode,
    input  logic                 rnd_mode,
    input  logic                 step_req,
    input  logic [1:0]           div_sel,
    input  logic [GRID_BITS-1:0] lfsr_q,
    input  logic [GRID_BITS-1:0] next_grid,
    output logic                 lfsr_en,
    output logic [GRID_BITS-1:0] grid_q,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 tick,
    output logic                 stable,
    output logic                 extinct
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_SEED,
        S_HOLD,
        S_RUN,
        S_COMMIT
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic             step_d;
    logic             step_rise;
    logic [DIV_W-1:0] div_limit;
    logic             grid_same;

    assign step_rise = step_req & ~step_d;
    // Terminal count; compared with >= so lowering div_sel mid-count commits at once.
    assign div_limit = (DIV_W'(BASE_DIV) << div_sel) - DIV_W'(1);
    assign grid_same = (next_grid == grid_q);
    assign lfsr_en   = (state == S_SEED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_CLEAR;
            grid_q    <= '0;
            gen_count <= '0;
            cnt       <= '0;
            tick      <= 1'b0;
            stable    <= 1'b0;
            extinct   <= 1'b1;
            step_d    <= 1'b0;
        end else begin
            step_d <= step_req;
            tick   <= 1'b0;
            case (state)
                S_CLEAR: begin
                    grid_q    <= '0;
                    gen_count <= '0;
                    stable    <= 1'b0;
                    extinct   <= 1'b1;
                    cnt       <= '0;
                    if (rst_mode)       state <= S_CLEAR;
                    else if (rnd_mode)  state <= S_SEED;
                    else if (play_mode) state <= S_RUN;
                    else                state <= S_HOLD;
                end
                S_SEED: begin
                    grid_q    <= lfsr_q;
                    gen_count <= '0;
                    stable    <= 1'b0;
                    extinct   <= (lfsr_q == '0);
                    cnt       <= '0;
                    if (rst_mode)       state <= S_CLEAR;
                    else if (rnd_mode)  state <= S_SEED;
                    else if (play_mode) state <= S_RUN;
                    else                state <= S_HOLD;
                end
                S_HOLD: begin
                    cnt <= '0;
                    if (rst_mode)       state <= S_CLEAR;
                    else if (rnd_mode)  state <= S_SEED;
                    else if (play_mode) state <= S_RUN;
                    else if (step_rise) state <= S_COMMIT;
                end
                S_RUN: begin
                    if (rst_mode) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end else if (rnd_mode) begin
                        state <= S_SEED;
                        cnt   <= '0;
                    end else if (!play_mode) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else if (cnt >= div_limit) begin
                        state <= S_COMMIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                S_COMMIT: begin
                    // Always completes, whatever the mode inputs do this cycle.
                    grid_q  <= next_grid;
                    stable  <= grid_same;
                    extinct <= (next_grid == '0);
                    tick    <= 1'b1;
                    cnt     <= '0;
                    if (!(&gen_count)) gen_count <= gen_count + GEN_W'(1);
                    if (rst_mode)                        state <= S_CLEAR;
                    else if (rnd_mode)                   state <= S_SEED;
                    else if (STOP_ON_STABLE && grid_same) state <= S_HOLD;
                    else if (play_mode)                  state <= S_RUN;
                    else                                 state <= S_HOLD;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_sequencer.sv
module tb_life_gen_sequencer;

    typedef struct packed {
        logic [63:0] grid;
        logic [15:0] gen;
        logic        tick;
        logic        stable;
        logic        extinct;
        logic        len;
    } exp_t;

    typedef struct {
        logic        rm;
        logic        pm;
        logic        nm;
        logic        st;
        logic [63:0] lq;
        logic [63:0] ng;
        int          n;
        exp_t        e;
    } vec_t;

    localparam logic [63:0] VA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VB = 64'hDEAD_BEEF_0000_1111;
    localparam logic [63:0] VC = 64'h8000_0000_0000_0001;
    localparam logic [63:0] VX = 64'h0F0F_F0F0_1234_5678;
    localparam logic [63:0] VZ = 64'h0000_0000_00FF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rst_mode, play_mode, rnd_mode, step_req;
    logic [1:0]  div_sel;
    logic [63:0] lfsr_q, next_grid;
    logic        lfsr_en, tick, stable, extinct;
    logic [63:0] grid_q;
    logic [15:0] gen_count;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    life_gen_sequencer #(
        .GRID_BITS(64), .BASE_DIV(4), .DIV_W(24), .GEN_W(16), .STOP_ON_STABLE(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .rst_mode(rst_mode), .play_mode(play_mode),
        .rnd_mode(rnd_mode), .step_req(step_req), .div_sel(div_sel),
        .lfsr_q(lfsr_q), .next_grid(next_grid), .lfsr_en(lfsr_en),
        .grid_q(grid_q), .gen_count(gen_count), .tick(tick),
        .stable(stable), .extinct(extinct)
    );

    function automatic exp_t mk(input logic [63:0] g, input int gen, input logic t,
                                input logic s, input logic x, input logic l);
        exp_t e;
        e.grid = g; e.gen = 16'(gen); e.tick = t; e.stable = s; e.extinct = x; e.len = l;
        return e;
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // pop and compare one time unit after the edge.
    task automatic apply(input logic rm, input logic pm, input logic nm, input logic st,
                         input logic [1:0] ds, input logic [63:0] lq, input logic [63:0] ng,
                         input exp_t e, input string name);
        exp_t got, want;
        rst_mode = rm; play_mode = pm; rnd_mode = nm; step_req = st;
        div_sel = ds; lfsr_q = lq; next_grid = ng;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got  = {grid_q, gen_count, tick, stable, extinct, lfsr_en};
        want = sb.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got grid=%h gen=%0d tick=%b stable=%b extinct=%b lfsr_en=%b, want grid=%h gen=%0d tick=%b stable=%b extinct=%b lfsr_en=%b",
                     name, got.grid, got.gen, got.tick, got.stable, got.extinct, got.len,
                     want.grid, want.gen, want.tick, want.stable, want.extinct, want.len);
        end
    endtask

    task automatic add_row(input logic rm, input logic pm, input logic nm, input logic st,
                           input logic [63:0] lq, input logic [63:0] ng, input int n, input exp_t e);
        vec_t v;
        v.rm = rm; v.pm = pm; v.nm = nm; v.st = st; v.lq = lq; v.ng = ng; v.n = n; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        logic [63:0] eg;
        int          egen;
        logic        estab;
        logic        commit;
        logic [1:0]  ds;
        logic [63:0] ng;

        // Table: CLEAR -> HOLD, 3-cycle seed, release, held step_req gives one step.
        add_row(0, 0, 0, 0, 64'd0, 64'd0, 1, mk(64'd0, 0, 0, 0, 1, 0));
        add_row(0, 0, 1, 0, VA,    64'd0, 1, mk(64'd0, 0, 0, 0, 1, 1));
        add_row(0, 0, 1, 0, VB,    64'd0, 1, mk(VB,    0, 0, 0, 0, 1));
        add_row(0, 0, 1, 0, VC,    64'd0, 1, mk(VC,    0, 0, 0, 0, 1));
        add_row(0, 0, 0, 0, VC,    64'd0, 1, mk(VC,    0, 0, 0, 0, 0));
        add_row(0, 0, 0, 1, VC,    VX,    1, mk(VC,    0, 0, 0, 0, 0));
        add_row(0, 0, 0, 1, VC,    VX,    1, mk(VX,    1, 1, 0, 0, 0));
        add_row(0, 0, 0, 1, VC,    VX,    8, mk(VX,    1, 0, 0, 0, 0));
        add_row(0, 0, 0, 0, VC,    VX,    1, mk(VX,    1, 0, 0, 0, 0));

        reset = 1'b0;
        apply(0, 0, 0, 0, 2'd0, 64'd0, 64'd0, mk(64'd0, 0, 0, 0, 1, 0), "reset0");
        apply(0, 0, 0, 0, 2'd0, 64'd0, 64'd0, mk(64'd0, 0, 0, 0, 1, 0), "reset1");
        reset = 1'b1;

        foreach (tbl[i])
            for (int r = 0; r < tbl[i].n; r++)
                apply(tbl[i].rm, tbl[i].pm, tbl[i].nm, tbl[i].st, 2'd1, tbl[i].lq, tbl[i].ng,
                      tbl[i].e, $sformatf("tbl%0d_%0d", i, r));

        // Free-run, div_sel=1: ticks 9 apart; div_sel 3->0 at cnt=10 commits on
        // the next cycle; then an unchanged-grid commit detours through HOLD.
        eg = VX; egen = 1; estab = 1'b0;
        for (int k = 1; k <= 51; k++) begin
            if (k <= 28)      ds = 2'd1;
            else if (k < 39)  ds = 2'd3;
            else              ds = 2'd0;
            ng = (k <= 40) ? ~eg : eg;
            commit = (k == 10 || k == 19 || k == 28 || k == 40 || k == 45 || k == 51);
            if (commit) begin
                estab = (ng == eg);
                eg    = ng;
                egen++;
            end
            apply(0, 1, 0, 0, ds, 64'd0, ng, mk(eg, egen, commit, estab, 0, 0),
                  $sformatf("run%0d", k));
        end

        // rst_mode and rnd_mode raised during COMMIT: commit lands, then CLEAR.
        apply(0, 0, 0, 0, 2'd0, VA, VZ, mk(eg, 7, 0, 1, 0, 0), "hold_idle");
        apply(0, 0, 0, 1, 2'd0, VA, VZ, mk(eg, 7, 0, 1, 0, 0), "hold_step");
        apply(1, 0, 1, 1, 2'd0, VA, VZ, mk(VZ, 8, 1, 0, 0, 0), "commit_lands");
        apply(1, 0, 1, 0, 2'd0, VA, VZ, mk(64'd0, 0, 0, 0, 1, 0), "clear_after");

        // Reset mid-RUN after one commit (div_sel=0: commit on edge 6).
        for (int k = 1; k <= 7; k++)
            apply(0, 1, 0, 0, 2'd0, 64'd0, VB,
                  (k >= 6) ? mk(VB, 1, k == 6, 0, 0, 0) : mk(64'd0, 0, 0, 0, 1, 0),
                  $sformatf("run_b%0d", k));
        reset = 1'b0;
        apply(0, 1, 0, 0, 2'd0, 64'd0, VB, mk(64'd0, 0, 0, 0, 1, 0), "mid_reset0");
        apply(0, 1, 0, 0, 2'd0, 64'd0, VB, mk(64'd0, 0, 0, 0, 1, 0), "mid_reset1");
        reset = 1'b1;
        apply(0, 0, 1, 0, 2'd0, VA, VB, mk(64'd0, 0, 0, 0, 1, 1), "post_reset_clear");
        apply(0, 0, 1, 0, 2'd0, VA, VB, mk(VA, 0, 0, 0, 0, 1), "post_reset_seed");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
